multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  IR[31:26] of the current instruction.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 mem_read, mem_write  output  1 each  memory access strobes.
REQ-007 i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-008 ir_write, pc_write, pc_write_cond  output  1 each  IR, PC and branch-PC write enables.
REQ-009 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write enable, dest select (1 rd, 0 rt), write-data select (1 MDR).
REQ-010 alu_src_a  output  1; alu_src_b  output  2  ALU operand selects (A: 0 PC/1 reg; B: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-011 alu_op  output  2  to the ALU control decoder: 00 add, 01 sub, 10 use funct.
REQ-012 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 state_dbg  output  4  current state code; instr_count  output  32  completed fetches.

Function
REQ-015 Supported opcodes SHALL be R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-016 States and codes SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-017 Transitions: FETCH->DECODE on mem_ready; DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addi), FETCH (other).
REQ-018 Transitions: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB on mem_ready; MEMWR->FETCH on mem_ready; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-019 FETCH, MEMRD and MEMWR SHALL hold, with strobes held, while mem_ready=0.
REQ-020 Outputs are a combinational decode of state; unlisted outputs SHALL be 0.
REQ-021 FETCH outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready.
REQ-022 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-023 MEMADR and ADDIEX outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-024 MEMRD outputs: mem_read=1, i_or_d=1. MEMWR outputs: mem_write=1, i_or_d=1.
REQ-025 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. ADDIWB: reg_write=1, reg_dst=0. ALUWB: reg_write=1, reg_dst=1.
REQ-026 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. BRANCH: same operands, alu_op=01, pc_write_cond=1, pc_src=01.
REQ-027 JUMP outputs: pc_write=1, pc_src=10.
REQ-028 illegal_op SHALL be 1 exactly in the DECODE cycle of an unsupported opcode.
REQ-029 instr_count SHALL increment by 1 on each FETCH cycle with mem_ready=1 and wrap from FFFFFFFF to 0.
REQ-030 Unused state codes 12-15 SHALL transition to FETCH on the next edge with all strobes 0.
REQ-031 Opcode SHALL be sampled only in DECODE and MEMADR; changes at other times have no effect.

Reset
REQ-032 rst_n low SHALL force state=FETCH and instr_count=0 immediately, including mid-instruction.
REQ-033 While rst_n is low, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write and illegal_op SHALL be 0.
REQ-034 After rst_n rises, the first edge SHALL evaluate FETCH normally.

Structure
REQ-035 Package mc_pkg SHALL hold opcode constants, state codes, and alu_op and alu_src_b/pc_src encodings, shared with the ALU control decoder.
REQ-036 A sub-module mc_next_state (pure combinational next-state logic) SHALL be instantiated; output decode stays in the top level.

Verification
REQ-037 lw, mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4; instr_count=1.
REQ-038 sw, mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; reg_write never 1.
REQ-039 R-type then beq -> alu_op=10 in EXEC; alu_op=01, pc_write_cond=1, pc_src=01 in BRANCH; 4+3 cycles total.
REQ-040 opcode 111111 -> illegal_op single pulse in DECODE, then FETCH; no write strobe asserted.
REQ-041 rst_n low during MEMRD -> state_dbg=0 and all strobes 0 asynchronously; instr_count=0.
REQ-042 instr_count preloaded near FFFFFFFF via forced fetches -> wraps to 0 after the FFFFFFFF completion.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg -- encodings shared by the multicycle control FSM and the ALU
// control decoder: opcodes, state codes, alu_op, alu_src_b and pc_src
// selects, plus a helper that recognises the supported opcodes.
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FSM state codes; 12-15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    // ALU control decoder request
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// mc_next_state -- pure combinational next-state logic of the multicycle
// control FSM.
//   state      : current state
//   opcode     : IR[31:26]; only consulted in DECODE and MEMADR
//   mem_ready  : memory completes the current access this cycle
//   next_state : state to load on the next rising edge
module mc_next_state
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output state_t     next_state
);

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      next_state = S_MEMRD;
                else if (opcode == OP_SW) next_state = S_MEMWR;
                else                      next_state = S_FETCH;
            end
            S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;  // write-back, branch, jump, unused codes
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control -- control unit of a multicycle MIPS-style datapath.
// Holds the state register and the completed-fetch counter; control
// outputs are a combinational decode of the current state.
//   clk, rst_n            : clock, asynchronous active-low reset
//   opcode, mem_ready     : instruction opcode, memory handshake
//   mem_read, mem_write, i_or_d            : memory strobes, address select
//   ir_write, pc_write, pc_write_cond      : IR / PC / branch-PC enables
//   reg_write, reg_dst, mem_to_reg         : register-file write controls
//   alu_src_a, alu_src_b, alu_op, pc_src   : datapath selects
//   illegal_op            : pulse in DECODE of an unsupported opcode
//   state_dbg, instr_count: current state code, completed fetch count
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal_op,
    output logic [3:0]  state_dbg,
    output logic [31:0] instr_count
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instr_count_q;

    mc_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            if (state_q == S_FETCH && mem_ready)
                instr_count_q <= instr_count_q + 32'd1;  // wraps naturally
        end
    end

    assign state_dbg   = state_q;
    assign instr_count = instr_count_q;

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_src        = PC_ALU;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;  // branch target precompute
                illegal_op = !op_supported(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            default: ;  // unused codes: everything stays 0
        endcase

        // The state register already reads FETCH during reset, so the
        // FETCH strobes must be suppressed explicitly.
        if (!rst_n) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed per-cycle vectors push the
// expected control word into a queue; a monitor pops and compares at
// each falling edge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state_dbg;
    logic [31:0] instr_count;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal_op(illegal_op), .state_dbg(state_dbg),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        mr, mw, iod, irw, pcw, pcwc, rw, rd, m2r, asa;
        logic [1:0]  asb, aop, psrc;
        logic        ill;
        logic [31:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-written control word for each state code.
    function automatic obs_t cw(input logic [3:0] st, input logic rdy,
                                input logic ill, input logic [31:0] cnt);
        obs_t o;
        o = '0;
        o.st  = st;
        o.ill = ill;
        o.cnt = cnt;
        case (st)
            4'd0:  begin o.mr = 1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            4'd1:  o.asb = 2'b11;
            4'd2:  begin o.asa = 1; o.asb = 2'b10; end
            4'd3:  begin o.mr = 1; o.iod = 1; end
            4'd4:  begin o.rw = 1; o.m2r = 1; end
            4'd5:  begin o.mw = 1; o.iod = 1; end
            4'd6:  begin o.asa = 1; o.aop = 2'b10; end
            4'd7:  begin o.rw = 1; o.rd = 1; end
            4'd8:  begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.psrc = 2'b01; end
            4'd9:  begin o.pcw = 1; o.psrc = 2'b10; end
            4'd10: begin o.asa = 1; o.asb = 2'b10; end
            4'd11: o.rw = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = '{state_dbg, mem_read, mem_write, i_or_d, ir_write, pc_write,
              pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src_a,
              alu_src_b, alu_op, pc_src, illegal_op, instr_count};
        return a;
    endfunction

    // One clock cycle of stimulus with the control word expected during it.
    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                        input logic ill, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        exp_q.push_back(cw(st, rdy, ill, cnt));
    endtask

    // Monitor: the control word is presented every cycle.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                check($sformatf("cycle%0d", cyc), 64'(sample()), 64'(e));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
        check({tag, "_strobes"},
              64'({mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_op}),
              64'd0);
        check({tag, "_count"}, 64'(instr_count), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = LW; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // lw with memory always ready: 0,1,2,3,4 then FETCH
        step(LW, 1, 0, 0, 0);
        step(LW, 1, 1, 0, 1);
        step(LW, 1, 2, 0, 1);
        step(SW, 1, 3, 0, 1);   // opcode changes in MEMRD are ignored
        step(RT, 1, 4, 0, 1);
        // sw with a FETCH stall and 3 not-ready cycles in MEMWR
        step(SW, 0, 0, 0, 1);
        step(SW, 1, 0, 0, 1);
        step(SW, 1, 1, 0, 2);
        step(SW, 1, 2, 0, 2);
        step(LW, 0, 5, 0, 2);
        step(BEQ, 0, 5, 0, 2);
        step(RT, 0, 5, 0, 2);
        step(RT, 1, 5, 0, 2);
        // R-type then beq
        step(RT, 1, 0, 0, 2);
        step(RT, 1, 1, 0, 3);
        step(RT, 1, 6, 0, 3);
        step(RT, 1, 7, 0, 3);
        step(BEQ, 1, 0, 0, 3);
        step(BEQ, 1, 1, 0, 4);
        step(BEQ, 1, 8, 0, 4);
        // unsupported opcode: illegal_op only in DECODE
        step(BAD, 1, 0, 0, 4);
        step(BAD, 1, 1, 1, 5);
        // addi and j
        step(ADDI, 1, 0, 0, 5);
        step(ADDI, 1, 1, 0, 6);
        step(ADDI, 1, 10, 0, 6);
        step(ADDI, 1, 11, 0, 6);
        step(JMP, 1, 0, 0, 6);
        step(JMP, 1, 1, 0, 7);
        step(JMP, 1, 9, 0, 7);
        // lw stalled in MEMRD, then asynchronous reset mid-cycle
        step(LW, 1, 0, 0, 7);
        step(LW, 1, 1, 0, 8);
        step(LW, 1, 2, 0, 8);
        step(LW, 0, 3, 0, 8);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Preload the counter near the top and watch it wrap.
        force dut.instr_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.instr_count_q;
        step(BAD, 1, 0, 0, 32'hFFFF_FFFE);
        step(BAD, 1, 1, 1, 32'hFFFF_FFFF);
        step(JMP, 1, 0, 0, 32'hFFFF_FFFF);
        step(JMP, 1, 1, 0, 32'h0000_0000);
        step(JMP, 0, 9, 0, 32'h0000_0000);
        step(JMP, 0, 0, 0, 32'h0000_0000);

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
